// File: rtl/cv32e40x_pending_arb_pkg.sv
// cv32e40x_pending_arb_pkg: legal sizing range for the pending arbiter.
package cv32e40x_pending_arb_pkg;
  localparam int unsigned PENDING_ARB_LEN_MIN = 2;
  localparam int unsigned PENDING_ARB_LEN_MAX = 64;
endpackage

// File: rtl/cv32e40x_ff_one.sv
// cv32e40x_ff_one: find-first-one, lowest set bit index plus an all-zero flag.
module cv32e40x_ff_one #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         in_i,
  output logic [$clog2(LEN)-1:0] first_one_o,
  output logic                   no_ones_o
);
  localparam int IDX_W = $clog2(LEN);
  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) first_one_o = in_i[i] ? IDX_W'(i) : first_one_o;
  end
  assign no_ones_o = ~|in_i;
endmodule

// File: rtl/cv32e40x_pending_arb.sv
// cv32e40x_pending_arb: sticky request collector feeding a registered
// fixed-priority (lowest index first) valid/ready output slot.
module cv32e40x_pending_arb
  import cv32e40x_pending_arb_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LEN-1:0]         set_i,
  input  logic [LEN-1:0]         mask_i,
  input  logic                   flush_i,
  output logic                   req_valid_o,
  output logic [$clog2(LEN)-1:0] req_index_o,
  input  logic                   req_ready_i,
  output logic [LEN-1:0]         pending_o
);
  localparam int IDX_W = $clog2(LEN);
  logic [LEN-1:0]   pending_q, pending_d, cand, clr_onehot;
  logic             valid_q, valid_d, sel_valid, no_ones, load;
  logic [IDX_W-1:0] index_q, index_d, sel_index;
  assign cand = pending_q & mask_i;
  cv32e40x_ff_one #(.LEN(LEN)) u_ff_one (
    .in_i        (cand),
    .first_one_o (sel_index),
    .no_ones_o   (no_ones)
  );
  assign sel_valid = ~no_ones;
  assign load      = !valid_q || req_ready_i;
  // A request leaves pending when it enters the slot; a same-cycle set re-arms it.
  always_comb begin
    clr_onehot = (load && sel_valid) ? ({{(LEN-1){1'b0}}, 1'b1} << sel_index) : '0;
    pending_d  = flush_i ? '0 : ((pending_q & ~clr_onehot) | set_i);
    valid_d    = flush_i ? 1'b0 : (load ? sel_valid : valid_q);
    index_d    = (!flush_i && load) ? sel_index : index_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
    end
  end
  assign req_valid_o = valid_q;
  assign req_index_o = index_q;
  assign pending_o   = pending_q;
  a_len_legal: assert property (@(posedge clk)
    (LEN >= int'(PENDING_ARB_LEN_MIN)) && (LEN <= int'(PENDING_ARB_LEN_MAX)));
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q && !req_ready_i && !flush_i |=> valid_q && $stable(index_q));
  a_index_range: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (32'(index_q) < LEN));
  a_set_kept: assert property (@(posedge clk) disable iff (!rst_n)
    !flush_i |=> ((pending_q & $past(set_i)) == $past(set_i)));
endmodule

// File: tb/tb_cv32e40x_pending_arb.sv
// tb_cv32e40x_pending_arb: directed scenarios plus random traffic against a queue-free
// bit-array reference model of the arbiter.
module tb_cv32e40x_pending_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] set_i = '0, mask_i = 8'hFF, pending_o;
  logic       flush_i = 1'b0, req_ready_i = 1'b0, req_valid_o;
  logic [2:0] req_index_o;
  int n_vec = 0, n_bad = 0;
  bit m_pend [8];
  bit m_valid;
  int m_index;

  cv32e40x_pending_arb #(.LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .mask_i(mask_i), .flush_i(flush_i),
    .req_valid_o(req_valid_o), .req_index_o(req_index_o), .req_ready_i(req_ready_i),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
    m_valid = 0;
    m_index = 0;
  endtask

  task automatic compare_model();
    check("pending", pending_o, model_pend());
    check("valid", req_valid_o, m_valid);
    if (m_valid) check("index", req_index_o, m_index);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare at the negedge.
  task automatic step(input logic [7:0] s, input logic [7:0] m, input logic f, input logic r);
    int sel;
    set_i = s; mask_i = m; flush_i = f; req_ready_i = r;
    @(posedge clk);
    if (f) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
      m_valid = 0;
    end else begin
      sel = -1;
      for (int i = 7; i >= 0; i--) if (m_pend[i] && m[i]) sel = i;
      if (!m_valid || r) begin
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          m_index = sel;
          m_pend[sel] = 0;
        end
      end
      for (int i = 0; i < 8; i++) if (s[i]) m_pend[i] = 1;
    end
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pending", pending_o, 8'h00);
    check("rst_valid", req_valid_o, 1'b0);
    check("rst_index", req_index_o, 3'd0);
    rst_n = 1'b1;
    repeat (10) step(8'h00, 8'hFF, 0, 0);
    check("idle_pending", pending_o, 8'h00);
    // Back-to-back service of 2, 5, 7.
    step(8'hA4, 8'hFF, 0, 1);
    check("lat_pending", pending_o, 8'hA4);
    check("lat_valid", req_valid_o, 1'b0);
    step(8'h00, 8'hFF, 0, 1);
    check("seq_a", {req_valid_o, req_index_o}, {1'b1, 3'd2});
    step(8'h00, 8'hFF, 0, 1);
    check("seq_b", {req_valid_o, req_index_o}, {1'b1, 3'd5});
    step(8'h00, 8'hFF, 0, 1);
    check("seq_c", {req_valid_o, req_index_o}, {1'b1, 3'd7});
    check("seq_pend", pending_o, 8'h00);
    step(8'h00, 8'hFF, 0, 1);
    check("seq_done", req_valid_o, 1'b0);
    // Hold with ready low.
    step(8'hA4, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(8'h00, 8'hFF, 0, 0);
      check("hold_idx", {req_valid_o, req_index_o}, {1'b1, 3'd2});
      check("hold_pend", pending_o, 8'hA0);
    end
    step(8'h00, 8'hFF, 0, 1);
    check("rel_a", req_index_o, 3'd5);
    step(8'h00, 8'hFF, 0, 1);
    check("rel_b", req_index_o, 3'd7);
    step(8'h00, 8'hFF, 0, 1);
    // Masked bit retained until the mask opens.
    step(8'h11, 8'hF0, 0, 1);
    step(8'h00, 8'hF0, 0, 1);
    check("mask_idx", {req_valid_o, req_index_o}, {1'b1, 3'd4});
    check("mask_pend", pending_o, 8'h01);
    step(8'h00, 8'hFF, 0, 1);
    check("unmask_idx", {req_valid_o, req_index_o}, {1'b1, 3'd0});
    // Re-request of the index being loaded.
    step(8'h08, 8'hFF, 0, 1);
    step(8'h08, 8'hFF, 0, 1);
    check("rereq_idx", {req_valid_o, req_index_o}, {1'b1, 3'd3});
    check("rereq_pend", pending_o, 8'h08);
    step(8'h00, 8'hFF, 0, 1);
    check("rereq_again", {req_valid_o, req_index_o}, {1'b1, 3'd3});
    step(8'h00, 8'hFF, 0, 1);
    check("rereq_done", req_valid_o, 1'b0);
    // Flush beats a same-cycle set.
    step(8'h0E, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    check("pre_flush", {req_valid_o, req_index_o, pending_o}, {1'b1, 3'd1, 8'h0C});
    step(8'h40, 8'hFF, 1, 0);
    check("flush_valid", req_valid_o, 1'b0);
    check("flush_pend", pending_o, 8'h00);
    // Random traffic with one asynchronous reset in the middle.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        rst_n = 1'b0;
        #1;
        check("arst_pending", pending_o, 8'h00);
        check("arst_valid", req_valid_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cv32e40x_pending_arb.md
# cv32e40x_pending_arb

Sticky request collector and fixed-priority dispatcher. Accumulates single-cycle request pulses into a pending register, picks the lowest-indexed enabled pending request with a find-first-one, and presents it as a registered index on a valid/ready output. Sits between the event sources (interrupt/debug/trigger-style pulse generators) and the controller logic that serves one event at a time.

## Interface
Parameters:
- LEN, default 32: number of request lines; legal range 2..64.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- set_i  in  LEN  request pulses; bit n high for one cycle marks request n pending.
- mask_i  in  LEN  enable per request; only bits with mask_i=1 are eligible for selection.
- flush_i  in  1  synchronous clear of all pending state and the output slot.
- req_valid_o  out  1  output slot holds a selected request.
- req_index_o  out  $clog2(LEN)  index of the selected request.
- req_ready_i  in  1  consumer accepts the slot this cycle when req_valid_o=1.
- pending_o  out  LEN  current pending register, not including the in-flight index.

## Operation
- State: pending_q[LEN], valid_q, index_q[IDX_W], with IDX_W = $clog2(LEN).
- Selection: combinational over cand = pending_q & mask_i. sel_valid = |cand. sel_index = the lowest set bit of cand. Index 0 has the highest priority.
- Load condition: load = !valid_q || req_ready_i.
- On load: valid_q <= sel_valid and index_q <= sel_index. If sel_valid=1, bit sel_index is cleared from pending_q in the same edge. A request moves out of pending when it enters the output slot, never on acceptance.
- Pending update: pending_q <= (pending_q & ~clr_onehot) | set_i.
- Simultaneous set/clear of the same bit: the set wins. The bit remains pending and is served again later.
- Re-request of the in-flight index via set_i: the bit becomes pending again. No merging with the slot.
- Hold: while valid_q && !req_ready_i, both req_index_o and req_valid_o stay stable. Deasserting mask_i for the held index does not revoke it.
- Flush: pending_q <= 0 and valid_q <= 0. flush_i has priority over set_i and load, so set_i in the flush cycle is dropped. index_q is left unchanged.
- Duplicate set_i pulses for an already pending bit are absorbed. There is no counting.
- A masked pending bit is retained indefinitely and becomes eligible on the cycle mask_i rises.

## Timing
- Reset values: pending_o=0, req_valid_o=0, req_index_o=0.
- Outputs are driven from flops. There is no combinational path from set_i, mask_i or req_ready_i to any output.
- Latency:
  - set_i at cycle 0 is visible on pending_o at cycle 1.
  - With the slot free and the bit the highest-priority candidate, req_valid_o is high at cycle 2.
- Throughput: one request per cycle with req_ready_i held high (back-to-back load on every accepting edge).
- Acceptance: the handshake completes on an edge where req_valid_o && req_ready_i. req_ready_i while req_valid_o=0 is ignored, apart from enabling a load.
- Reset asserted mid-operation clears all state immediately. No request survives reset.

## Structure
- Instantiates the existing cv32e40x_ff_one (LEN) on cand. Its first_one_o drives sel_index and ~no_ones_o drives sel_valid. No other sub-module.
- clr_onehot is decoded locally from sel_index gated by load && sel_valid.
- No new typedefs. IDX_W is a local parameter. Nothing is added to cv32e40x_pkg.
- Assertions:
  - req_index_o and req_valid_o stable while valid && !ready.
  - req_index_o < LEN when valid.
  - No bit is both cleared and lost when set in the same cycle.

## Test plan
All scenarios use LEN=8, mask_i=8'hFF unless stated.
- Reset release, no stimulus: pending_o=8'h00, req_valid_o=0 for 10 cycles.
- set_i=8'b1010_0100 pulse, req_ready_i=1: req_index_o sequence 2, 5, 7 on consecutive cycles starting 2 cycles after the pulse, then req_valid_o=0 and pending_o=0.
- Same pulse with req_ready_i=0: req_index_o=2 held stable for 5 cycles with pending_o=8'hA0. Raise ready and observe 5 then 7.
- mask_i=8'hF0, set_i=8'h11: index 4 is served and bit 0 stays pending (pending_o=8'h01). Set mask_i=8'hFF and index 0 is served next.
- Index 3 loaded into the slot while set_i[3] pulses in the load cycle: pending_o[3]=1 afterwards. Index 3 is delivered twice in total.
- flush_i while slot valid (index 1), pending=8'h0C and set_i=8'h40 in the same cycle: next cycle req_valid_o=0 and pending_o=0.
